// File: rtl/mdio_slave_responder_if.sv
// MDIO pad pins and register-file port of the PHY-side MDIO responder.
// The slave modport is the responder; the master modport is the pad/register-file side.
interface mdio_slave_responder_if;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_oe;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr_en;
    logic        reg_rd_req;
    logic [15:0] reg_rdata;
    logic        frame_err;
    logic        busy;

    modport slave (
        input  mdc, mdio_i, reg_rdata,
        output mdio_o, mdio_oe, reg_addr, reg_wdata, reg_wr_en, reg_rd_req, frame_err, busy
    );

    modport master (
        output mdc, mdio_i, reg_rdata,
        input  mdio_o, mdio_oe, reg_addr, reg_wdata, reg_wr_en, reg_rd_req, frame_err, busy
    );
endinterface

// File: rtl/mdio_slave_responder.sv
// Clause 22 MDIO target: oversamples mdc/mdio in the clk domain, decodes frames for PHY_ADDR
// and maps them onto a one-clk write strobe / read request register port.
module mdio_slave_responder #(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         PRE_LEN  = 32,
    parameter int         RD_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    mdio_slave_responder_if.slave bus
);

    typedef enum logic [3:0] {
        S_HUNT  = 4'd0,
        S_ST    = 4'd1,
        S_OP    = 4'd2,
        S_PHYAD = 4'd3,
        S_REGAD = 4'd4,
        S_TA    = 4'd5,
        S_WDATA = 4'd6,
        S_RDATA = 4'd7,
        S_SKIP  = 4'd8
    } state_t;

    localparam logic [5:0] PRE_LEN_C = 6'(PRE_LEN);
    localparam logic [1:0] RD_LAT_C  = 2'(RD_LAT);

    logic [1:0]  mdc_sync_r;
    logic [1:0]  mdio_sync_r;
    logic        mdc_prev_r;
    logic        rise_s;
    logic        fall_s;
    logic        bit_s;

    state_t      state_r;
    logic [5:0]  pre_cnt_r;
    logic [4:0]  bit_cnt_r;
    logic        op_hi_r;
    logic        is_read_r;
    logic [4:0]  phyad_r;
    logic [3:0]  regad_r;
    logic [14:0] wshift_r;
    logic [15:0] rd_shift_r;
    logic [1:0]  rd_lat_cnt_r;

    logic        mdio_o_r;
    logic        mdio_oe_r;
    logic [4:0]  reg_addr_r;
    logic [15:0] reg_wdata_r;
    logic        reg_wr_en_r;
    logic        reg_rd_req_r;
    logic        frame_err_r;
    logic        busy_r;

    // Two-flop synchronisers on the asynchronous pins plus mdc edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdc_sync_r  <= 2'b00;
            mdio_sync_r <= 2'b00;
            mdc_prev_r  <= 1'b0;
        end else begin
            mdc_sync_r  <= {mdc_sync_r[0], bus.mdc};
            mdio_sync_r <= {mdio_sync_r[0], bus.mdio_i};
            mdc_prev_r  <= mdc_sync_r[1];
        end
    end

    assign rise_s = mdc_sync_r[1] & ~mdc_prev_r;
    assign fall_s = ~mdc_sync_r[1] & mdc_prev_r;
    assign bit_s  = mdio_sync_r[1];

    // Read-latency countdown: reaches 1 in the cycle where reg_rdata is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_lat_cnt_r <= 2'd0;
        end else if (reg_rd_req_r) begin
            rd_lat_cnt_r <= RD_LAT_C;
        end else if (rd_lat_cnt_r != 2'd0) begin
            rd_lat_cnt_r <= rd_lat_cnt_r - 2'd1;
        end else begin
            rd_lat_cnt_r <= 2'd0;
        end
    end

    // Frame decoder: bit fields advance on mdc rises, read data is driven on mdc falls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_HUNT;
            pre_cnt_r    <= 6'd0;
            bit_cnt_r    <= 5'd0;
            op_hi_r      <= 1'b0;
            is_read_r    <= 1'b0;
            phyad_r      <= 5'd0;
            regad_r      <= 4'd0;
            wshift_r     <= 15'd0;
            rd_shift_r   <= 16'd0;
            mdio_o_r     <= 1'b0;
            mdio_oe_r    <= 1'b0;
            reg_addr_r   <= 5'd0;
            reg_wdata_r  <= 16'd0;
            reg_wr_en_r  <= 1'b0;
            reg_rd_req_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            reg_wr_en_r  <= 1'b0;
            reg_rd_req_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state_r)
                S_HUNT: begin
                    if (rise_s) begin
                        if (bit_s) begin
                            if (pre_cnt_r != 6'd63) begin
                                pre_cnt_r <= pre_cnt_r + 6'd1;
                            end
                        end else if (pre_cnt_r >= PRE_LEN_C) begin
                            // This 0 is the first ST bit.
                            pre_cnt_r <= 6'd0;
                            busy_r    <= 1'b1;
                            state_r   <= S_ST;
                        end else begin
                            pre_cnt_r <= 6'd0;
                        end
                    end
                end
                S_ST: begin
                    if (rise_s) begin
                        if (bit_s) begin
                            bit_cnt_r <= 5'd0;
                            state_r   <= S_OP;
                        end else begin
                            frame_err_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= S_HUNT;
                        end
                    end
                end
                S_OP: begin
                    if (rise_s) begin
                        op_hi_r <= bit_s;
                        if (bit_cnt_r == 5'd0) begin
                            bit_cnt_r <= 5'd1;
                        end else begin
                            bit_cnt_r <= 5'd0;
                            case ({op_hi_r, bit_s})
                                2'b01: begin
                                    is_read_r <= 1'b0;
                                    state_r   <= S_PHYAD;
                                end
                                2'b10: begin
                                    is_read_r <= 1'b1;
                                    state_r   <= S_PHYAD;
                                end
                                default: begin
                                    frame_err_r <= 1'b1;
                                    busy_r      <= 1'b0;
                                    state_r     <= S_HUNT;
                                end
                            endcase
                        end
                    end
                end
                S_PHYAD: begin
                    if (rise_s) begin
                        phyad_r <= {phyad_r[3:0], bit_s};
                        if (bit_cnt_r == 5'd4) begin
                            bit_cnt_r <= 5'd0;
                            state_r   <= S_REGAD;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                S_REGAD: begin
                    if (rise_s) begin
                        regad_r <= {regad_r[2:0], bit_s};
                        if (bit_cnt_r == 5'd4) begin
                            bit_cnt_r <= 5'd0;
                            if (phyad_r == PHY_ADDR) begin
                                reg_addr_r <= {regad_r, bit_s};
                                if (is_read_r) begin
                                    reg_rd_req_r <= 1'b1;
                                    state_r      <= S_RDATA;
                                end else begin
                                    state_r <= S_TA;
                                end
                            end else begin
                                // Not our PHY: let TA and data pass without touching the bus.
                                state_r <= S_SKIP;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                S_TA: begin
                    if (rise_s) begin
                        if (bit_cnt_r == 5'd1) begin
                            bit_cnt_r <= 5'd0;
                            state_r   <= S_WDATA;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                S_WDATA: begin
                    if (rise_s) begin
                        wshift_r <= {wshift_r[13:0], bit_s};
                        if (bit_cnt_r == 5'd15) begin
                            reg_wdata_r <= {wshift_r, bit_s};
                            reg_wr_en_r <= 1'b1;
                            busy_r      <= 1'b0;
                            bit_cnt_r   <= 5'd0;
                            state_r     <= S_HUNT;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                S_RDATA: begin
                    // bit_cnt_r counts mdc falls since the last REGAD rise (F0..F18).
                    if (fall_s) begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                        case (bit_cnt_r)
                            5'd0: begin
                                mdio_oe_r <= 1'b0;
                            end
                            5'd1: begin
                                mdio_oe_r <= 1'b1;
                                mdio_o_r  <= 1'b0;
                            end
                            5'd18: begin
                                mdio_oe_r <= 1'b0;
                                mdio_o_r  <= 1'b0;
                                busy_r    <= 1'b0;
                                bit_cnt_r <= 5'd0;
                                state_r   <= S_HUNT;
                            end
                            default: begin
                                mdio_o_r   <= rd_shift_r[15];
                                rd_shift_r <= {rd_shift_r[14:0], 1'b0};
                            end
                        endcase
                    end
                end
                S_SKIP: begin
                    if (rise_s) begin
                        if (bit_cnt_r == 5'd17) begin
                            bit_cnt_r <= 5'd0;
                            busy_r    <= 1'b0;
                            state_r   <= S_HUNT;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                default: begin
                    mdio_oe_r <= 1'b0;
                    busy_r    <= 1'b0;
                    bit_cnt_r <= 5'd0;
                    pre_cnt_r <= 6'd0;
                    state_r   <= S_HUNT;
                end
            endcase
            if (rd_lat_cnt_r == 2'd1) begin
                rd_shift_r <= bus.reg_rdata;
            end
        end
    end

    assign bus.mdio_o     = mdio_o_r;
    assign bus.mdio_oe    = mdio_oe_r;
    assign bus.reg_addr   = reg_addr_r;
    assign bus.reg_wdata  = reg_wdata_r;
    assign bus.reg_wr_en  = reg_wr_en_r;
    assign bus.reg_rd_req = reg_rd_req_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_mdio_slave_responder.sv
// Self-checking bench: an MDIO master model drives frames; expected outcomes come from a
// frame-level reference model of the Clause 22 target behaviour.
module tb_mdio_slave_responder;
    localparam logic [4:0] PHY_ADDR = 5'd1;
    localparam int         PRE_LEN  = 32;
    localparam int         RD_LAT   = 2;
    localparam int         HALF     = 8;

    localparam int K_IGN  = 0;
    localparam int K_ERR  = 1;
    localparam int K_WR   = 2;
    localparam int K_RD   = 3;
    localparam int K_SKIP = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdio_slave_responder_if bus ();

    mdio_slave_responder #(
        .PHY_ADDR(PHY_ADDR),
        .PRE_LEN (PRE_LEN),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [4:0]  exp_addr;

    // Passive monitor of the register port.
    int          mon_wr = 0;
    int          mon_rd = 0;
    int          mon_err = 0;
    int          mon_oe = 0;
    logic [4:0]  mon_wr_addr = 5'd0;
    logic [15:0] mon_wr_data = 16'd0;
    logic [4:0]  mon_rd_addr = 5'd0;

    always @(negedge clk) begin
        if (bus.reg_wr_en === 1'b1) begin
            mon_wr      <= mon_wr + 1;
            mon_wr_addr <= bus.reg_addr;
            mon_wr_data <= bus.reg_wdata;
        end
        if (bus.reg_rd_req === 1'b1) begin
            mon_rd      <= mon_rd + 1;
            mon_rd_addr <= bus.reg_addr;
        end
        if (bus.frame_err === 1'b1) mon_err <= mon_err + 1;
        if (bus.mdio_oe === 1'b1) mon_oe <= mon_oe + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: classify a frame purely from its fields.
    function automatic int model_kind(input int pre, input logic [1:0] st,
                                      input logic [1:0] op, input logic [4:0] phy);
        if (pre < PRE_LEN) return K_IGN;
        if (st != 2'b01) return K_ERR;
        if (op != 2'b01 && op != 2'b10) return K_ERR;
        if (phy != PHY_ADDR) return K_SKIP;
        return (op == 2'b01) ? K_WR : K_RD;
    endfunction

    // One mdc period: data changes with mdc low, master samples the line just before the rise.
    task automatic mdc_bit(input logic b, output logic s_o, output logic s_oe);
        bus.mdc    = 1'b0;
        bus.mdio_i = b;
        repeat (HALF) @(posedge clk);
        #1;
        s_o  = bus.mdio_o;
        s_oe = bus.mdio_oe;
        bus.mdc = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int pre, input logic [1:0] st, input logic [1:0] op,
                              input logic [4:0] phy, input logic [4:0] rga, input logic [15:0] d,
                              output logic [17:0] rx_o, output logic [17:0] rx_oe,
                              output logic busy_mid);
        logic [13:0] hdr;
        logic        s_o;
        logic        s_oe;
        bit          done;
        hdr      = {st, op, phy, rga};
        rx_o     = 18'd0;
        rx_oe    = 18'd0;
        busy_mid = 1'b0;
        done     = 1'b0;
        fork
            begin
                for (int i = 0; i < pre; i++) mdc_bit(1'b1, s_o, s_oe);
                for (int i = 13; i >= 0; i--) mdc_bit(hdr[i], s_o, s_oe);
                busy_mid = bus.busy;
                for (int i = 0; i < 18; i++) begin
                    if (op == 2'b10) mdc_bit(1'b1, s_o, s_oe);
                    else if (i < 2) mdc_bit((i == 0) ? 1'b1 : 1'b0, s_o, s_oe);
                    else mdc_bit(d[17 - i], s_o, s_oe);
                    rx_o[i]  = s_o;
                    rx_oe[i] = s_oe;
                end
                bus.mdc    = 1'b0;
                bus.mdio_i = 1'b1;
                repeat (20) @(posedge clk);
                #1;
                done = 1'b1;
            end
            begin
                // Register file: data valid only in the cycle RD_LAT after the request.
                bus.reg_rdata = ~d;
                for (int n = 0; n < 1500 && !done && bus.reg_rd_req !== 1'b1; n++) @(negedge clk);
                if (bus.reg_rd_req === 1'b1) begin
                    repeat (RD_LAT) @(negedge clk);
                    bus.reg_rdata = d;
                    @(negedge clk);
                    bus.reg_rdata = ~d;
                end
            end
        join
    endtask

    task automatic run_frame(input string tag, input int pre, input logic [1:0] st,
                             input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] rga, input logic [15:0] d);
        int          kind;
        int          wr0, rd0, err0, oe0;
        logic [17:0] rx_o, rx_oe, exp_o;
        logic        busy_mid;
        kind = model_kind(pre, st, op, phy);
        wr0  = mon_wr;
        rd0  = mon_rd;
        err0 = mon_err;
        oe0  = mon_oe;
        send_frame(pre, st, op, phy, rga, d, rx_o, rx_oe, busy_mid);
        chk({tag, ".wr_cnt"}, 32'(mon_wr - wr0), 32'(kind == K_WR));
        chk({tag, ".rd_cnt"}, 32'(mon_rd - rd0), 32'(kind == K_RD));
        chk({tag, ".err_cnt"}, 32'(mon_err - err0), 32'(kind == K_ERR));
        chk({tag, ".busy_mid"}, 32'(busy_mid), 32'(kind == K_WR || kind == K_RD || kind == K_SKIP));
        if (kind == K_WR) begin
            exp_addr = rga;
            chk({tag, ".wr_addr"}, 32'(mon_wr_addr), 32'(rga));
            chk({tag, ".wr_data"}, 32'(mon_wr_data), 32'(d));
        end
        if (kind == K_RD) begin
            exp_addr = rga;
            exp_o = 18'd0;
            for (int j = 0; j < 16; j++) exp_o[2 + j] = d[15 - j];
            chk({tag, ".rd_addr"}, 32'(mon_rd_addr), 32'(rga));
            chk({tag, ".rx_oe"}, 32'(rx_oe), 32'h0003_FFFE);
            chk({tag, ".rx_data"}, 32'(rx_o), 32'(exp_o));
        end else begin
            chk({tag, ".oe_cnt"}, 32'(mon_oe - oe0), 32'd0);
        end
        chk({tag, ".reg_addr"}, 32'(bus.reg_addr), 32'(exp_addr));
        chk({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
        chk({tag, ".oe_end"}, 32'(bus.mdio_oe), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation time budget exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        logic        s_o;
        logic        s_oe;
        logic [13:0] hdr;
        int          sel;
        int          pre;
        logic [1:0]  op;
        logic [4:0]  phy;

        rst           = 1'b1;
        bus.mdc       = 1'b0;
        bus.mdio_i    = 1'b1;
        bus.reg_rdata = 16'h0000;
        exp_addr      = 5'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst.mdio_oe", 32'(bus.mdio_oe), 32'd0);
        chk("rst.mdio_o", 32'(bus.mdio_o), 32'd0);
        chk("rst.wr_en", 32'(bus.reg_wr_en), 32'd0);
        chk("rst.rd_req", 32'(bus.reg_rd_req), 32'd0);
        chk("rst.frame_err", 32'(bus.frame_err), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.reg_addr", 32'(bus.reg_addr), 32'd0);
        chk("rst.reg_wdata", 32'(bus.reg_wdata), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        run_frame("t1_write", 32, 2'b01, 2'b01, 5'd1, 5'h1A, 16'hBEEF);
        run_frame("t2_read", 32, 2'b01, 2'b10, 5'd1, 5'h02, 16'h4F51);
        run_frame("t3_read_phy7", 32, 2'b01, 2'b10, 5'h07, 5'h05, 16'h1234);
        run_frame("t3_write_after", 32, 2'b01, 2'b01, 5'd1, 5'h0C, 16'hA5C3);
        run_frame("t4_pre31", 31, 2'b01, 2'b01, 5'd1, 5'h1A, 16'hBEEF);
        run_frame("t4_pre32", 32, 2'b01, 2'b01, 5'd1, 5'h13, 16'h0F0F);
        run_frame("t4_op11", 32, 2'b01, 2'b11, 5'd1, 5'h04, 16'h5555);
        run_frame("t4_st00", 32, 2'b00, 2'b01, 5'd1, 5'h08, 16'h3333);
        run_frame("t4_write_long_pre", 63, 2'b01, 2'b01, 5'd1, 5'h1F, 16'h0001);

        for (int r = 0; r < 10; r++) begin
            sel = int'($urandom_range(0, 5));
            pre = 32 + int'($urandom_range(0, 6));
            phy = PHY_ADDR;
            op  = 2'b01;
            case (sel)
                0, 1: op = 2'b01;
                2, 3: op = 2'b10;
                4: begin
                    phy = 5'($urandom_range(2, 31));
                    op  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
                end
                default: op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            endcase
            run_frame("rand", pre, 2'b01, op, phy, 5'($urandom), 16'($urandom));
        end

        // Reset in the middle of a read's data phase.
        bus.reg_rdata = 16'hC3A5;
        hdr = {2'b01, 2'b10, 5'd1, 5'h03};
        for (int i = 0; i < 32; i++) mdc_bit(1'b1, s_o, s_oe);
        for (int i = 13; i >= 0; i--) mdc_bit(hdr[i], s_o, s_oe);
        for (int i = 0; i < 10; i++) mdc_bit(1'b1, s_o, s_oe);
        chk("t5.oe_before_rst", 32'(bus.mdio_oe), 32'd1);
        chk("t5.busy_before_rst", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        bus.mdc = 1'b0;
        @(posedge clk);
        #1;
        chk("t5.oe_after_rst", 32'(bus.mdio_oe), 32'd0);
        chk("t5.busy_after_rst", 32'(bus.busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_addr = 5'd0;
        chk("t5.reg_addr_rst", 32'(bus.reg_addr), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        run_frame("t5_write_after_rst", 32, 2'b01, 2'b01, 5'd1, 5'h11, 16'h7E81);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
